// File: rtl/i2c_regbank_pkg.sv
// i2c_regbank_pkg
// Purpose: shared constants and types for the I2C register bank.
//   NUM_REGS_DEF   default number of 8-bit registers
//   REG_*          well-known register indices used by the LED controller
//   REG_RESET_VAL  value every register takes on reset
//   state_t        write-pointer / commit state of the bank
package i2c_regbank_pkg;

  localparam int         NUM_REGS_DEF  = 16;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_BRIGHT    = 8'h01;
  localparam logic [7:0] REG_MODE      = 8'h02;
  localparam logic [7:0] REG_LED_BASE  = 8'h04;

  localparam logic [7:0] REG_RESET_VAL = 8'h00;

  // IDLE: pointer will be loaded from the address; ADDR_SET: pointer loaded,
  // nothing staged; PENDING: shadow holds bytes not yet committed.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ADDR_SET = 2'd1,
    ST_PENDING  = 2'd2
  } state_t;

endpackage

// File: rtl/i2c_regbank_edge_rise.sv
// edge_rise
// Purpose: registered rising-edge detector for a level input.
//   clk    system clock
//   reset  synchronous, active-high reset (delayed copy cleared)
//   sig    level input
//   rise   high in the first cycle sig is seen high after being low
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q_r;

  // One-cycle delayed copy of the input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q_r <= 1'b0;
    end else begin
      sig_q_r <= sig;
    end
  end

  assign rise = sig & ~sig_q_r;

endmodule

// File: rtl/i2c_regbank.sv
// i2c_regbank
// Purpose: register bank behind the I2C slave receiver. Tracks a per-
// transaction write pointer with auto-increment and drives the LED
// controller configuration from the active bank.
// Build option I2C_REGBANK_SHADOW_EN:
//   defined   - bytes are staged in a shadow bank and committed atomically on stop
//   undefined - bytes write the active bank directly; busy_o is tied low
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   i2c_address     register address from the receiver
//   i2c_data        received data byte
//   i2c_data_valid  level strobe, its rising edge marks one byte
//   i2c_start       one-cycle start / repeated-start pulse
//   i2c_stop        one-cycle stop pulse
//   regs_o          active registers, reg k at [8k+7:8k]
//   update_o        one-cycle pulse when the active bank changes
//   wr_error_o      sticky, set by a write to an index >= NUM_REGS
//   busy_o          high while uncommitted shadow writes are pending
module i2c_regbank
  import i2c_regbank_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            i2c_address,
  input  logic [7:0]            i2c_data,
  input  logic                  i2c_data_valid,
  input  logic                  i2c_start,
  input  logic                  i2c_stop,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  update_o,
  output logic                  wr_error_o,
  output logic                  busy_o
);

  localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic             byte_rise_s;
  logic             byte_ev_s;
  logic             in_range_s;
  logic             wr_en_s;
  logic             commit_s;
  logic [7:0]       ptr_r;
  logic [7:0]       ptr_next_s;
  logic [PTR_W-1:0] wr_idx_s;
  logic             first_r;
  logic             update_r;
  logic             wr_error_r;
  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       active_r [NUM_REGS];

  edge_rise u_dv_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (i2c_data_valid),
    .rise  (byte_rise_s)
  );

  // A start in the same cycle as a byte edge discards the byte.
  assign byte_ev_s  = byte_rise_s & ~i2c_start;
  // 9-bit compare so NUM_REGS=256 still works.
  assign in_range_s = ({1'b0, ptr_next_s} < 9'(NUM_REGS));
  assign wr_en_s    = byte_ev_s & in_range_s;
  assign wr_idx_s   = ptr_next_s[PTR_W-1:0];

  // Pointer candidate: address on the first byte, else 8-bit wrapping increment.
  always_comb begin
    ptr_next_s = ptr_r;
    if (first_r) begin
      ptr_next_s = i2c_address;
    end else begin
      ptr_next_s = ptr_r + 8'd1;
    end
  end

  // Pointer and first-byte flag; start/stop re-arm the address load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r   <= 8'd0;
      first_r <= 1'b1;
    end else begin
      if (byte_ev_s) begin
        ptr_r <= ptr_next_s;
      end
      if (i2c_start || i2c_stop) begin
        first_r <= 1'b1;
      end else if (byte_ev_s) begin
        first_r <= 1'b0;
      end
    end
  end

  // Sticky out-of-range write flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_error_r <= 1'b0;
    end else if (byte_ev_s && !in_range_s) begin
      wr_error_r <= 1'b1;
    end
  end

  // Next state: stop always returns to IDLE; staged bytes keep PENDING across repeated starts.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_ADDR_SET: begin
        if (i2c_stop) begin
          state_next_s = ST_IDLE;
        end else if (wr_en_s) begin
`ifdef I2C_REGBANK_SHADOW_EN
          state_next_s = ST_PENDING;
`else
          state_next_s = ST_ADDR_SET;
`endif
        end else if (i2c_start) begin
          state_next_s = ST_IDLE;
        end else if (byte_ev_s) begin
          state_next_s = ST_ADDR_SET;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_PENDING: begin
        if (i2c_stop) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PENDING;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

`ifdef I2C_REGBANK_SHADOW_EN
  logic [7:0] shadow_r      [NUM_REGS];
  logic [7:0] shadow_next_s [NUM_REGS];

  // Shadow with this cycle's byte merged in, so a byte coinciding with stop is committed.
  always_comb begin
    shadow_next_s = shadow_r;
    if (wr_en_s) begin
      shadow_next_s[wr_idx_s] = i2c_data;
    end else begin
      shadow_next_s[wr_idx_s] = shadow_r[wr_idx_s];
    end
  end

  assign commit_s = i2c_stop & ((state_r == ST_PENDING) | wr_en_s);

  // Shadow bank; only reset clears it, so aborted bytes ride along with the next commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_r[k] <= REG_RESET_VAL;
      end
    end else begin
      shadow_r <= shadow_next_s;
    end
  end

  // Active bank takes the whole merged shadow on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        active_r[k] <= REG_RESET_VAL;
      end
    end else if (commit_s) begin
      active_r <= shadow_next_s;
    end
  end

  assign busy_o = (state_r == ST_PENDING);
`else
  assign commit_s = wr_en_s;

  // Active bank written directly by each accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        active_r[k] <= REG_RESET_VAL;
      end
    end else if (wr_en_s) begin
      active_r[wr_idx_s] <= i2c_data;
    end
  end

  assign busy_o = 1'b0;
`endif

  // Update pulse one cycle after the active bank is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      update_r <= 1'b0;
    end else begin
      update_r <= commit_s;
    end
  end

  // Flatten the active bank onto the output bus.
  always_comb begin
    regs_o = {(NUM_REGS*8){1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[8*k +: 8] = active_r[k];
    end
  end

  assign update_o   = update_r;
  assign wr_error_o = wr_error_r;

endmodule
